// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, prescale width and parity helper.
package uart_pkg;

  localparam int unsigned PRESCALE_W   = 6;
  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned PARITY_MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Parity bit for a data word: even parity when parity_type=0, odd when 1.
  // Zero-extension does not change the XOR reduction, so any width up to
  // PARITY_MAX_W can be passed in.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                       input logic                    parity_type);
    return (^data) ^ parity_type;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: cycle counter within a bit and data bit index.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  active_i,
  input  logic                  in_data_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_done_o,
  output logic                  last_data_bit_o,
  output logic [BIT_W-1:0]      bit_idx_next_o
);

  logic [PRESCALE_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

  // prescale_i is already clamped to at least 1 by the caller.
  assign bit_done_o      = (cyc_cnt_q == (prescale_i - PRESCALE_W'(1)));
  assign last_data_bit_o = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
  assign bit_idx_next_o  = bit_cnt_d;

  // Next counter values: cycle count wraps at each bit boundary, bit index only advances in DATA.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (!active_i || bit_done_o) begin
      cyc_cnt_d = '0;
    end else begin
      cyc_cnt_d = cyc_cnt_q + PRESCALE_W'(1);
    end
    if (!in_data_i) begin
      bit_cnt_d = '0;
    end else if (bit_done_o) begin
      bit_cnt_d = last_data_bit_o ? '0 : bit_cnt_q + BIT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic [PRESCALE_W-1:0] p_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  bit_done;
  logic                  last_data_bit;
  logic [BIT_W-1:0]      bit_idx_next;
  logic [PRESCALE_W-1:0] prescale_eff;

  // A prescale of 0 behaves as 1 cycle per bit.
  assign prescale_eff = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

  uart_tx_bit_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_W      (BIT_W)
  ) u_bit_timer (
    .clk_i           (CLK),
    .rst_i           (RST),
    .active_i        (state_q != IDLE),
    .in_data_i       (state_q == DATA),
    .prescale_i      (p_q),
    .bit_done_o      (bit_done),
    .last_data_bit_o (last_data_bit),
    .bit_idx_next_o  (bit_idx_next)
  );

  // Frame FSM; the line value is registered from the state/bit being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      p_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Data_Valid) begin
            data_q    <= P_DATA;
            par_en_q  <= parity_enable;
            par_bit_q <= calc_parity(PARITY_MAX_W'(P_DATA), parity_type);
            p_q       <= prescale_eff;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= data_q[bit_idx_next];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (!last_data_bit) begin
              tx_q <= data_q[bit_idx_next];
            end else if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that forms the transmit half of the UART system, pairing with the existing receiver. It accepts a parallel word through a valid/busy handshake and serialises it onto TX_OUT, LSB first. Frame format: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit. The bit period is Prescale CLK cycles, with the same Prescale encoding the receiver uses, so both ends share one clock and one Prescale register.

Parameters:
DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_Valid  input  1  P_DATA is valid; accepted when busy=0
parity_enable  input  1  1: include parity bit in frame
parity_type  input  1  0: even parity, 1: odd parity
Prescale  input  6  CLK cycles per bit; a value of 0 is treated as 1
TX_OUT  output  1  serial line, idle high, registered
busy  output  1  frame in progress, registered

Behaviour:
- Interface: one clock CLK. Reset RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset: TX_OUT=1, busy=0, FSM=IDLE, bit and cycle counters=0, holding registers=0. Reset overrides everything, including mid-frame: on the next edge the line returns high with no stop bit emitted.
- Accept: on a rising edge where Data_Valid=1 and busy=0 (FSM in IDLE), latch P_DATA, parity_enable, parity_type and Prescale into internal registers.
- Parity is computed at accept time: XOR of the data bits, inverted when parity_type=1.
- Input changes after accept have no effect on the current frame.
- Data_Valid while busy=1 is ignored. Nothing is queued or buffered.
- Latency: TX_OUT drives the start bit (0) and busy=1 starting from the cycle after the accept edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on accept.
  - START→DATA after P cycles, where P = latched Prescale, or 1 if the latched value is 0.
  - DATA holds each bit for P cycles. Bit index runs 0..DATA_WIDTH-1. After the last bit's P cycles, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY→STOP after P cycles.
  - STOP drives 1 for P cycles, then goes to IDLE.
- busy is 1 in every non-IDLE state and goes to 0 on the same edge the FSM enters IDLE.
- Cycle counter: 6 bits, counts 0..P-1 and wraps to 0 at each bit boundary. Bit counter: $clog2(DATA_WIDTH) bits, wide enough to hold DATA_WIDTH-1.
- TX_OUT is a registered function of the next state and next bit index, so there are no combinational glitches on the line.
- Frame length: (1 + DATA_WIDTH + parity_enable + 1) × P cycles of busy=1.
- Back-to-back frames: Data_Valid may be held high. The next frame is accepted in the first cycle busy=0. The line stays high for exactly 1 CLK between the end of one stop bit and the next start bit.
- Prescale=1: one CLK per bit, and the same state transitions still apply.

Decomposition:
- Shared package uart_pkg holds:
  - the tx state enum typedef tx_state_e (IDLE, START, DATA, PARITY, STOP);
  - localparam PRESCALE_W = 6;
  - a parity function calc_parity(data, parity_type), reusable by the receiver's parity checker.
- One sub-module, uart_tx_bit_timer. It holds the cycle counter and bit counter and outputs bit_done (cycle count == P-1) and last_data_bit. The FSM, holding registers and output register stay in uart_tx.

Test Plan:
1. Prescale=8, parity_enable=1, parity_type=0, pulse Data_Valid with P_DATA=0xA5 → TX_OUT, starting 1 cycle after accept, holds each of 0,1,0,1,0,0,1,0,1,0,1 for 8 cycles. busy=1 for exactly 88 cycles, then TX_OUT=1.
2. Prescale=16, parity_enable=0, P_DATA=0x3C → bits 0,0,0,1,1,1,1,0,0,1 for 16 cycles each; busy high for 160 cycles.
3. Prescale=4, parity_enable=1, parity_type=1, P_DATA=0xFF → parity bit=1, frame 0,1×8,1,1; busy 44 cycles.
4. Data_Valid held high with P_DATA=0x55 then 0xAA, Prescale=8, no parity → two complete frames separated by exactly one idle-high CLK. A P_DATA change during frame 1 does not alter its bits.
5. Assert RST during DATA bit 3 of a frame → the next edge gives TX_OUT=1 and busy=0. With Data_Valid=0, the line stays high; a fresh accept afterward produces a correct full frame.
6. Prescale=0 and Prescale=1, P_DATA=0x01, no parity → 1-cycle bits 0,1,0,0,0,0,0,0,0,1; busy 10 cycles.
